// File: rtl/psum_lif_accumulator_if.sv
// Handshake bundle between the LIF accumulator and its neighbours: partial-sum
// lanes, stored potential, threshold and the result/spike stream.
interface psum_lif_accumulator_if #(
  parameter int NUM_PSUM   = 3,
  parameter int PSUM_WIDTH = 9,
  parameter int POT_WIDTH  = 8
);
  logic [NUM_PSUM-1:0]            psum_valid;
  logic [NUM_PSUM*PSUM_WIDTH-1:0] psum_data;
  logic [NUM_PSUM-1:0]            psum_ready;
  logic                           mem_valid;
  logic signed [POT_WIDTH-1:0]    mem_data;
  logic                           mem_ready;
  logic signed [POT_WIDTH-1:0]    threshold;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [POT_WIDTH-1:0]    out_potential;
  logic                           out_spike;
  logic [7:0]                     out_adder_idx;
  logic                           sat_flag;

  modport master (
    output psum_valid, psum_data, mem_valid, mem_data, threshold, out_ready,
    input  psum_ready, mem_ready, out_valid, out_potential, out_spike,
           out_adder_idx, sat_flag
  );

  modport slave (
    input  psum_valid, psum_data, mem_valid, mem_data, threshold, out_ready,
    output psum_ready, mem_ready, out_valid, out_potential, out_spike,
           out_adder_idx, sat_flag
  );
endinterface

// File: rtl/psum_lif_accumulator.sv
// Leaky-integrate-and-fire accumulator: buffers NUM_PSUM partial-sum lanes, adds
// them to the stored membrane potential, thresholds and emits spike + new potential.
module psum_lif_accumulator #(
  parameter int NUM_PSUM   = 3,
  parameter int PSUM_WIDTH = 9,
  parameter int POT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SATURATE   = 1,
  parameter int RESET_MODE = 0,
  parameter int ADDER_IDX  = 0
) (
  input logic                    clk,
  input logic                    reset,
  psum_lif_accumulator_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = POT_WIDTH + PSUM_WIDTH + 3;

  localparam logic signed [SUM_W-1:0] POT_MAX =
    {{(SUM_W-POT_WIDTH+1){1'b0}}, {(POT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] POT_MIN =
    {{(SUM_W-POT_WIDTH+1){1'b1}}, {(POT_WIDTH-1){1'b0}}};

  typedef enum logic {
    S_IDLE,
    S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [POT_WIDTH-1:0]   pot_q, pot_d;
  logic                   spike_q, spike_d;
  logic                   sat_q, sat_d;

  logic [NUM_PSUM-1:0]    lane_nonempty;
  logic [PSUM_WIDTH-1:0]  lane_head [NUM_PSUM];
  logic                   fire;

  assign fire = (state_q == S_IDLE) && (&lane_nonempty) && bus.mem_valid;

  // Per-lane FIFOs; the head is read combinationally so the pop and the sum
  // happen in the same cycle. No fall-through: a fresh push is seen next cycle.
  for (genvar gi = 0; gi < NUM_PSUM; gi++) begin : g_lane
    logic [PSUM_WIDTH-1:0] fifo_ram [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full;
    logic                  push;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign push     = bus.psum_valid[gi] && !full;
    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(fire);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        fifo_ram[wr_ptr_q] <= bus.psum_data[gi*PSUM_WIDTH +: PSUM_WIDTH];
      end
    end

    assign lane_head[gi]       = fifo_ram[rd_ptr_q];
    assign lane_nonempty[gi]   = (count_q != '0);
    assign bus.psum_ready[gi]  = !full;
  end

  // Narrow a full-width sum to POT_WIDTH; flags any value that does not fit,
  // whether it was clamped or wrapped.
  function automatic logic [POT_WIDTH:0] fit_pot(input logic signed [SUM_W-1:0] v);
    logic [POT_WIDTH-1:0] trunc;
    logic                 ovf;
    trunc = v[POT_WIDTH-1:0];
    ovf   = (v != {{(SUM_W-POT_WIDTH){trunc[POT_WIDTH-1]}}, trunc});
    if (SATURATE != 0 && v > POT_MAX) begin
      trunc = {1'b0, {(POT_WIDTH-1){1'b1}}};
    end else if (SATURATE != 0 && v < POT_MIN) begin
      trunc = {1'b1, {(POT_WIDTH-1){1'b0}}};
    end
    return {ovf, trunc};
  endfunction

  logic signed [SUM_W-1:0] sum_full;
  logic signed [SUM_W-1:0] diff_full;
  logic [POT_WIDTH:0]      sum_fit;
  logic [POT_WIDTH:0]      diff_fit;
  logic [POT_WIDTH-1:0]    r_pot;
  logic                    spike_cond;

  always_comb begin
    sum_full = {{(SUM_W-POT_WIDTH){bus.mem_data[POT_WIDTH-1]}}, bus.mem_data};
    for (int i = 0; i < NUM_PSUM; i++) begin
      sum_full = sum_full +
                 {{(SUM_W-PSUM_WIDTH){lane_head[i][PSUM_WIDTH-1]}}, lane_head[i]};
    end
  end

  assign sum_fit    = fit_pot(sum_full);
  assign r_pot      = sum_fit[POT_WIDTH-1:0];
  assign spike_cond = $signed(r_pot) >= $signed(bus.threshold);
  assign diff_full  = {{(SUM_W-POT_WIDTH){r_pot[POT_WIDTH-1]}}, r_pot} -
                      {{(SUM_W-POT_WIDTH){bus.threshold[POT_WIDTH-1]}}, bus.threshold};
  assign diff_fit   = fit_pot(diff_full);

  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    spike_d = spike_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          state_d = S_OUT;
          sat_d   = sat_q | sum_fit[POT_WIDTH];
          if (spike_cond) begin
            spike_d = 1'b1;
            if (RESET_MODE == 0) begin
              pot_d = '0;
            end else begin
              pot_d = diff_fit[POT_WIDTH-1:0];
              sat_d = sat_d | diff_fit[POT_WIDTH];
            end
          end else begin
            spike_d = 1'b0;
            pot_d   = r_pot;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pot_q   <= '0;
      spike_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pot_q   <= pot_d;
      spike_q <= spike_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.mem_ready     = fire;
  assign bus.out_valid     = (state_q == S_OUT);
  assign bus.out_potential = pot_q;
  assign bus.out_spike     = spike_q;
  assign bus.out_adder_idx = 8'(ADDER_IDX);
  assign bus.sat_flag      = sat_q;

endmodule

// File: tb/tb_psum_lif_accumulator.sv
// Directed bench: three accumulators (saturating/zero-reset, saturating/subtract,
// wrapping/zero-reset) share one stimulus stream and are checked against hand values.
module tb_psum_lif_accumulator;

  logic        clk;
  logic        reset;
  logic [2:0]  psum_valid;
  logic [26:0] psum_data;
  logic        mem_valid;
  logic signed [7:0] mem_data;
  logic signed [7:0] threshold;
  logic        out_ready;

  int n_vec;
  int n_err;

  psum_lif_accumulator_if if_a ();
  psum_lif_accumulator_if if_b ();
  psum_lif_accumulator_if if_c ();

  assign if_a.psum_valid = psum_valid;
  assign if_a.psum_data  = psum_data;
  assign if_a.mem_valid  = mem_valid;
  assign if_a.mem_data   = mem_data;
  assign if_a.threshold  = threshold;
  assign if_a.out_ready  = out_ready;
  assign if_b.psum_valid = psum_valid;
  assign if_b.psum_data  = psum_data;
  assign if_b.mem_valid  = mem_valid;
  assign if_b.mem_data   = mem_data;
  assign if_b.threshold  = threshold;
  assign if_b.out_ready  = out_ready;
  assign if_c.psum_valid = psum_valid;
  assign if_c.psum_data  = psum_data;
  assign if_c.mem_valid  = mem_valid;
  assign if_c.mem_data   = mem_data;
  assign if_c.threshold  = threshold;
  assign if_c.out_ready  = out_ready;

  psum_lif_accumulator #(.SATURATE(1), .RESET_MODE(0), .ADDER_IDX(0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  psum_lif_accumulator #(.SATURATE(1), .RESET_MODE(1), .ADDER_IDX(5)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));
  psum_lif_accumulator #(.SATURATE(0), .RESET_MODE(0), .ADDER_IDX(9)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input int p0, input int p1, input int p2);
    psum_data[0 +: 9]  = p0[8:0];
    psum_data[9 +: 9]  = p1[8:0];
    psum_data[18 +: 9] = p2[8:0];
  endtask

  task automatic check_out(input string tag, input int pa, input int sa, input int pb,
                           input int sb, input int pc, input int sc, input int sat);
    chk({tag, " a.valid"}, int'(if_a.out_valid), 1);
    chk({tag, " b.valid"}, int'(if_b.out_valid), 1);
    chk({tag, " c.valid"}, int'(if_c.out_valid), 1);
    chk({tag, " a.pot"}, int'($signed(if_a.out_potential)), pa);
    chk({tag, " a.spike"}, int'(if_a.out_spike), sa);
    chk({tag, " b.pot"}, int'($signed(if_b.out_potential)), pb);
    chk({tag, " b.spike"}, int'(if_b.out_spike), sb);
    chk({tag, " c.pot"}, int'($signed(if_c.out_potential)), pc);
    chk({tag, " c.spike"}, int'(if_c.out_spike), sc);
    chk({tag, " a.sat"}, int'(if_a.sat_flag), sat);
    chk({tag, " c.sat"}, int'(if_c.sat_flag), sat);
    chk({tag, " a.mem_ready_low"}, int'(if_a.mem_ready), 0);
  endtask

  // Push one full set, present the potential, fire, observe one result, drain it.
  task automatic fire_vec(input string tag, input int p0, input int p1, input int p2,
                          input int m, input int thr,
                          input int pa, input int sa, input int pb, input int sb,
                          input int pc, input int sc, input int sat);
    set_lanes(p0, p1, p2);
    psum_valid = 3'b111;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    mem_valid  = 1'b1;
    mem_data   = m[7:0];
    threshold  = thr[7:0];
    @(negedge clk);
    chk({tag, " a.mem_ready"}, int'(if_a.mem_ready), 1);
    chk({tag, " c.mem_ready"}, int'(if_c.mem_ready), 1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check_out(tag, pa, sa, pb, sb, pc, sc, sat);
    @(posedge clk); #1;
    chk({tag, " a.valid_drop"}, int'(if_a.out_valid), 0);
    $display("vec %s: a=%0d/%0d b=%0d/%0d c=%0d/%0d", tag,
             $signed(if_a.out_potential), if_a.out_spike,
             $signed(if_b.out_potential), if_b.out_spike,
             $signed(if_c.out_potential), if_c.out_spike);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    psum_valid = 3'b000;
    psum_data  = '0;
    mem_valid  = 1'b0;
    mem_data   = '0;
    threshold  = 8'sd64;
    out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a.valid", int'(if_a.out_valid), 0);
    chk("rst a.pot", int'($signed(if_a.out_potential)), 0);
    chk("rst a.spike", int'(if_a.out_spike), 0);
    chk("rst a.sat", int'(if_a.sat_flag), 0);
    chk("rst a.psum_ready", int'(if_a.psum_ready), 7);
    chk("rst a.mem_ready", int'(if_a.mem_ready), 0);
    chk("rst a.idx", int'(if_a.out_adder_idx), 0);
    chk("rst b.idx", int'(if_b.out_adder_idx), 5);
    chk("rst c.idx", int'(if_c.out_adder_idx), 9);
    @(posedge clk); #1;
    reset = 1'b0;

    //       tag    p0   p1   p2   mem  thr   a-pot spk  b-pot spk  c-pot spk  sat
    fire_vec("sum55", 10,  20,  5,  20,  64,   55, 0,   55, 0,   55, 0,   0);
    fire_vec("sum65", 10,  20,  5,  30,  64,    0, 1,    1, 1,    0, 1,   0);
    fire_vec("sat700", 200, 200, 200, 100, 127, 0, 1,    0, 1,  -68, 0,   1);
    fire_vec("wrap200", 100, 0,  0, 100, 127,   0, 1,    0, 1,  -56, 0,   1);

    // Backpressure: result held while lane 0 fills; no second fire until release.
    out_ready = 1'b0;
    set_lanes(1, 2, 3);
    psum_valid = 3'b111;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    mem_valid  = 1'b1;
    mem_data   = 8'sd4;
    threshold  = 8'sd64;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      psum_valid = 3'b000;
      if (k < 4) begin
        set_lanes(7, 0, 0);
        psum_valid = 3'b001;
      end else if (k == 4) begin
        set_lanes(0, 8, 9);
        psum_valid = 3'b110;
      end else if (k == 5) begin
        set_lanes(99, 0, 0);
        psum_valid = 3'b001;
      end
      @(negedge clk);
      chk("hold a.valid", int'(if_a.out_valid), 1);
      chk("hold a.pot", int'($signed(if_a.out_potential)), 10);
      chk("hold a.spike", int'(if_a.out_spike), 0);
      chk("hold a.mem_ready", int'(if_a.mem_ready), 0);
      if (k >= 4) chk("hold a.ready0_full", int'(if_a.psum_ready[0]), 0);
      else        chk("hold a.ready0_open", int'(if_a.psum_ready[0]), 1);
      @(posedge clk); #1;
    end
    psum_valid = 3'b000;
    out_ready  = 1'b1;
    @(negedge clk);
    chk("release a.valid", int'(if_a.out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("refire a.mem_ready", int'(if_a.mem_ready), 1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check_out("refire28", 28, 0, 28, 0, 28, 0, 1);
    @(posedge clk); #1;
    $display("vec refire28: a=%0d", $signed(if_a.out_potential));

    // Partial arrival: lane 2 empty keeps the block idle.
    set_lanes(0, 5, 0);
    psum_valid = 3'b010;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    mem_valid  = 1'b1;
    mem_data   = 8'sd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("partial a.mem_ready", int'(if_a.mem_ready), 0);
      chk("partial a.valid", int'(if_a.out_valid), 0);
      @(posedge clk); #1;
    end
    set_lanes(0, 0, 6);
    psum_valid = 3'b100;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    @(negedge clk);
    chk("partial a.fire", int'(if_a.mem_ready), 1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check_out("partial18", 18, 0, 18, 0, 18, 0, 1);
    @(posedge clk); #1;
    $display("vec partial18: a=%0d", $signed(if_a.out_potential));

    // Reset while holding a result with queued entries.
    out_ready = 1'b0;
    set_lanes(0, 1, 1);
    psum_valid = 3'b110;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    mem_valid  = 1'b1;
    mem_data   = 8'sd1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst a.pot", int'($signed(if_a.out_potential)), 10);
    @(posedge clk); #1;
    set_lanes(7, 3, 0);
    psum_valid = 3'b011;
    @(posedge clk); #1;
    psum_valid = 3'b010;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    chk("pre_rst a.valid", int'(if_a.out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst a.valid", int'(if_a.out_valid), 0);
    chk("async_rst b.valid", int'(if_b.out_valid), 0);
    chk("async_rst a.psum_ready", int'(if_a.psum_ready), 7);
    chk("async_rst a.pot", int'($signed(if_a.out_potential)), 0);
    chk("async_rst a.sat", int'(if_a.sat_flag), 0);
    chk("async_rst c.sat", int'(if_c.sat_flag), 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    mem_valid = 1'b1;
    mem_data  = 8'sd5;
    @(negedge clk);
    chk("post_rst a.mem_ready", int'(if_a.mem_ready), 0);
    @(posedge clk); #1;
    set_lanes(2, 3, 4);
    psum_valid = 3'b111;
    @(posedge clk); #1;
    psum_valid = 3'b000;
    @(negedge clk);
    chk("post_rst a.fire", int'(if_a.mem_ready), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_out("post_rst14", 14, 0, 14, 0, 14, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst a.single", int'(if_a.out_valid), 0);
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    $display("vec post_rst14: a=%0d", $signed(if_a.out_potential));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_lif_accumulator.md
Name: psum_lif_accumulator

Overview:
- Clocked, parametrised successor to the three-input partial-sum adder block.
- Accepts NUM_PSUM partial-sum streams, each buffered in its own FIFO, plus one stored membrane potential per firing step.
- Sums all inputs with selectable saturation, compares the result against a runtime threshold, and emits the spike flag and updated potential.
- The output is written back to neuron memory and forwarded to the NoC encoder.

Parameters:
- NUM_PSUM, 3, number of partial-sum input lanes (1..8)
- PSUM_WIDTH, 9, signed two's-complement width of each partial sum
- POT_WIDTH, 8, signed width of membrane potential, threshold and output potential
- FIFO_DEPTH, 4, entries per lane FIFO (power of two, >=2)
- SATURATE, 1, 1 = clamp sum to POT_WIDTH signed range; 0 = wrap (truncate)
- RESET_MODE, 0, 0 = reset potential to zero on spike; 1 = subtract threshold
- ADDER_IDX, 0, constant block index driven on out_adder_idx

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- psum_valid  in  NUM_PSUM  per-lane data valid
- psum_data  in  NUM_PSUM*PSUM_WIDTH  lane i occupies bits [i*PSUM_WIDTH +: PSUM_WIDTH]
- psum_ready  out  NUM_PSUM  per-lane ready (FIFO not full)
- mem_valid  in  1  stored potential valid
- mem_data  in  POT_WIDTH  stored membrane potential (signed)
- mem_ready  out  1  potential consumed this cycle
- threshold  in  POT_WIDTH  signed firing threshold, sampled in the FIRE cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_potential  out  POT_WIDTH  updated potential
- out_spike  out  1  neuron fired
- out_adder_idx  out  8  equals ADDER_IDX
- sat_flag  out  1  sticky: any saturation or wrap overflow since reset

Behaviour:
- Reset values:
  - all FIFOs empty; psum_ready = all ones; mem_ready = 0
  - out_valid = 0, out_potential = 0, out_spike = 0, sat_flag = 0
  - out_adder_idx = ADDER_IDX at all times
  - FSM enters IDLE
- Lane FIFO:
  - psum_ready[i] = !full[i], derived from the registered count.
  - A push occurs when psum_valid[i] && psum_ready[i].
  - A push into a full FIFO is impossible because ready is low.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged. On an empty FIFO the pushed entry is not visible to the pop in the same cycle; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE:
  - fire_cond = every lane non-empty && mem_valid.
  - mem_ready = fire_cond, combinational, IDLE only.
  - On fire_cond:
    - pop the head of every lane
    - compute sum = sign-extended psums + mem_data at full width POT_WIDTH+PSUM_WIDTH+3
    - apply SATURATE to POT_WIDTH and set sat_flag if clamped or wrapped
    - compare (signed) to threshold and register the result; go to OUT
  - Otherwise stay in IDLE. Partial arrivals wait indefinitely.
- Spike rule:
  - If r >= threshold: out_spike = 1; out_potential = 0 when RESET_MODE = 0, else r - threshold, saturated the same way.
  - Otherwise out_spike = 0 and out_potential = r.
- FSM OUT:
  - out_valid = 1; out_potential and out_spike are held stable while out_ready = 0.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - The next fire can occur in the cycle after return, giving a throughput of one result per 2 cycles.
  - Lanes keep accepting pushes while in OUT.
- Latency: fire_cond cycle -> out_valid high on the next rising edge (1 cycle).
- Reset asserted mid-operation: FIFO contents are discarded, any pending output is dropped, and outputs return to reset values immediately (asynchronous).
- sat_flag clears only on reset.

Test Plan:
- Defaults, threshold = 64; push lane psums 10, 20, 5 and mem 20 -> one cycle after fire: out_valid = 1, out_potential = 55, out_spike = 0, mem_ready pulsed once.
- Same, with mem = 30 (sum 65) -> out_spike = 1, out_potential = 0; rerun with RESET_MODE = 1 -> out_potential = 1.
- SATURATE = 1, psums 200, 200, 200 and mem 100, threshold = 127 -> sum clamps to 127, out_spike = 1, sat_flag = 1 and stays 1 afterwards; SATURATE = 0 with psums 100, 0, 0 and mem 100 (sum 200) -> out_potential = -56, sat_flag = 1.
- Hold out_ready = 0 for 10 cycles while pushing 4 more psums on lane 0 -> outputs stable; psum_ready[0] = 0 after 4 entries; no further fire until release.
- Lanes 0 and 1 filled, lane 2 empty, mem_valid = 1 -> mem_ready = 0 and no output; push lane 2 -> fire in the following cycle.
- Assert reset while in OUT with FIFOs holding 2 entries -> out_valid = 0 immediately, all psum_ready = 1, and a subsequent single full set yields exactly one result.
